// File: rtl/array_add_ctrl.sv
// array_add_ctrl: walks a job of num_lines cache lines, reading both operands,
// handshaking with the adder and writing each sum back, one line in flight at a time.
module array_add_ctrl #(
   parameter int CACHE_WIDTH = 512,
   parameter int ADDR_WIDTH  = 32,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  src1_addr,
   input  logic [ADDR_WIDTH-1:0]  src2_addr,
   input  logic [ADDR_WIDTH-1:0]  dst_addr,
   input  logic [CNT_WIDTH-1:0]   num_lines,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_WIDTH-1:0]   lines_done,
   output logic                   err,
   output logic                   rd_req_valid,
   output logic [ADDR_WIDTH-1:0]  rd_req_addr,
   output logic                   rd_req_tag,
   input  logic                   rd_req_almfull,
   input  logic                   rd_rsp_valid,
   input  logic                   rd_rsp_tag,
   input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
   output logic                   wr_req_valid,
   output logic [ADDR_WIDTH-1:0]  wr_req_addr,
   output logic [CACHE_WIDTH-1:0] wr_req_data,
   input  logic                   wr_req_almfull,
   input  logic                   wr_rsp_valid,
   output logic                   add_en,
   output logic [CACHE_WIDTH-1:0] add_a,
   output logic [CACHE_WIDTH-1:0] add_b,
   input  logic [CACHE_WIDTH-1:0] add_res,
   input  logic                   add_ready
);

   typedef enum logic [3:0] {
      S_IDLE, S_RD1, S_RD2, S_WAIT_RD, S_ADD, S_WAIT_ADD, S_WR, S_WAIT_WR, S_FIN
   } state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] src1_q, src2_q, dst_q;
   logic [CNT_WIDTH-1:0]  num_q, idx, idx_inc;
   logic                  got_a, got_b, take_a, take_b, rsp_window;

   // Operand 1 may come back while operand 2 is still being requested.
   always_comb begin
      idx_inc    = idx + CNT_WIDTH'(1);
      rsp_window = (state == S_RD2) || (state == S_WAIT_RD);
      take_a     = rd_rsp_valid && rsp_window && !rd_rsp_tag && !got_a;
      take_b     = rd_rsp_valid && rsp_window &&  rd_rsp_tag && !got_b;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      rd_req_valid = 1'b0;
      rd_req_addr  = '0;
      rd_req_tag   = 1'b0;
      wr_req_valid = 1'b0;
      wr_req_addr  = '0;
      add_en       = 1'b0;
      case (state)
         S_IDLE: if (start) state_nx = (num_lines == '0) ? S_FIN : S_RD1;
         S_RD1: begin
            rd_req_addr = src1_q + ADDR_WIDTH'(idx);
            if (!rd_req_almfull) begin
               rd_req_valid = 1'b1;
               state_nx     = S_RD2;
            end
         end
         S_RD2: begin
            rd_req_addr = src2_q + ADDR_WIDTH'(idx);
            rd_req_tag  = 1'b1;
            if (!rd_req_almfull) begin
               rd_req_valid = 1'b1;
               state_nx     = S_WAIT_RD;
            end
         end
         S_WAIT_RD: if ((got_a || take_a) && (got_b || take_b)) state_nx = S_ADD;
         S_ADD: begin
            add_en   = 1'b1;
            state_nx = S_WAIT_ADD;
         end
         S_WAIT_ADD: if (add_ready) state_nx = S_WR;
         S_WR: begin
            wr_req_addr = dst_q + ADDR_WIDTH'(idx);
            if (!wr_req_almfull) begin
               wr_req_valid = 1'b1;
               state_nx     = S_WAIT_WR;
            end
         end
         S_WAIT_WR: if (wr_rsp_valid) state_nx = (idx_inc == num_q) ? S_FIN : S_RD1;
         S_FIN:     state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         lines_done  <= '0;
         err         <= 1'b0;
         src1_q      <= '0;
         src2_q      <= '0;
         dst_q       <= '0;
         num_q       <= '0;
         idx         <= '0;
         got_a       <= 1'b0;
         got_b       <= 1'b0;
         add_a       <= '0;
         add_b       <= '0;
         wr_req_data <= '0;
      end else begin
         done <= (state == S_FIN);
         if (state == S_IDLE && start) begin
            src1_q     <= src1_addr;
            src2_q     <= src2_addr;
            dst_q      <= dst_addr;
            num_q      <= num_lines;
            idx        <= '0;
            lines_done <= '0;
            err        <= 1'b0;
            got_a      <= 1'b0;
            got_b      <= 1'b0;
            busy       <= 1'b1;
         end
         if (state == S_FIN) busy <= 1'b0;
         if (take_a) begin
            add_a <= rd_rsp_data;
            got_a <= 1'b1;
         end
         if (take_b) begin
            add_b <= rd_rsp_data;
            got_b <= 1'b1;
         end
         // Responses arriving after an abandoned job land in IDLE and are silently dropped.
         if (rd_rsp_valid && !take_a && !take_b && state != S_IDLE) err <= 1'b1;
         if (state == S_WAIT_ADD && add_ready) wr_req_data <= add_res;
         if (state == S_WAIT_WR && wr_rsp_valid) begin
            lines_done <= lines_done + CNT_WIDTH'(1);
            idx        <= idx_inc;
            got_a      <= 1'b0;
            got_b      <= 1'b0;
         end
      end
   end

endmodule
